// File: rtl/gpu_pkg.sv
// ---------------------------------------------------------------------------
// gpu_pkg
// Shared definitions for the 2D draw path.
//   line_state_t : rasteriser state (IDLE, SETUP, DRAW)
//   ADDR_CONCAT  : pixel address is {x,y}
//   ADDR_LINEAR  : pixel address is y*pitch + x
// ---------------------------------------------------------------------------
package gpu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      DRAW  = 2'd2
   } line_state_t;

   localparam int ADDR_CONCAT = 0;
   localparam int ADDR_LINEAR = 1;

endpackage

// File: rtl/bresen_step.sv
// ---------------------------------------------------------------------------
// bresen_step
// Combinational single Bresenham step. Given the current position, address
// and error term, produces the position/address/error of the next pixel and
// flags whether that next pixel is the line end point.
//   x, y, addr        : current pixel
//   err, dx, dy       : signed error term and deltas (dy is -|dy|)
//   sx_neg, sy_neg    : step direction, 1 = decrement
//   x_end, y_end      : line end point
//   x_n, y_n, addr_n  : stepped pixel
//   err_n             : stepped error term
//   next_is_end       : stepped pixel equals the end point
// ---------------------------------------------------------------------------
module bresen_step
   import gpu_pkg::*;
#(
   parameter int X_W       = 10,
   parameter int Y_W       = 9,
   parameter int D_W       = 12,
   parameter int ADDR_W    = 19,
   parameter int ADDR_MODE = ADDR_CONCAT,
   parameter int FB_WIDTH  = 640
) (
   input  logic [X_W-1:0]          x,
   input  logic [Y_W-1:0]          y,
   input  logic [ADDR_W-1:0]       addr,
   input  logic signed [D_W-1:0]   err,
   input  logic signed [D_W-1:0]   dx,
   input  logic signed [D_W-1:0]   dy,
   input  logic                    sx_neg,
   input  logic                    sy_neg,
   input  logic [X_W-1:0]          x_end,
   input  logic [Y_W-1:0]          y_end,
   output logic [X_W-1:0]          x_n,
   output logic [Y_W-1:0]          y_n,
   output logic [ADDR_W-1:0]       addr_n,
   output logic signed [D_W-1:0]   err_n,
   output logic                    next_is_end
);

   // Row stride for a y step in linear mode; a y step in concat mode is
   // handled by rebuilding {x,y} instead.
   localparam logic [ADDR_W-1:0] PITCH = ADDR_W'(FB_WIDTH);

   logic signed [D_W:0]  e2;
   logic signed [D_W:0]  dx_e;
   logic signed [D_W:0]  dy_e;
   logic                 step_x;
   logic                 step_y;
   logic [ADDR_W-1:0]    addr_x;
   logic [ADDR_W-1:0]    addr_lin;

   always_comb begin
      // One extra bit so 2*err cannot overflow.
      e2       = {err, 1'b0};
      dx_e     = {dx[D_W-1], dx};
      dy_e     = {dy[D_W-1], dy};
      // Both decisions use the same pre-step e2.
      step_x   = (e2 >= dy_e);
      step_y   = (e2 <= dx_e);

      err_n    = err + (step_x ? dy : '0) + (step_y ? dx : '0);

      x_n      = step_x ? (sx_neg ? x - X_W'(1) : x + X_W'(1)) : x;
      y_n      = step_y ? (sy_neg ? y - Y_W'(1) : y + Y_W'(1)) : y;

      addr_x   = step_x ? (sx_neg ? addr - ADDR_W'(1) : addr + ADDR_W'(1)) : addr;
      addr_lin = step_y ? (sy_neg ? addr_x - PITCH : addr_x + PITCH) : addr_x;

      addr_n   = (ADDR_MODE == ADDR_LINEAR) ? addr_lin : ADDR_W'({x_n, y_n});

      next_is_end = (x_n == x_end) && (y_n == y_end);
   end

endmodule

// File: rtl/bresen_line_gen.sv
// ---------------------------------------------------------------------------
// bresen_line_gen
// Bresenham line rasteriser. Accepts one line command over valid/ready,
// spends one SETUP cycle computing deltas and the start address, then emits
// one pixel per accepted handshake on a back-pressurable stream.
//   clk, rst                 : clock, synchronous active-high reset
//   cmd_valid/cmd_ready      : command handshake
//   cmd_x0,cmd_y0,cmd_x1,cmd_y1 : end points
//   cmd_skip_last            : suppress the end pixel (polyline joints)
//   abort                    : drop the current line immediately
//   pix_valid/pix_ready      : pixel stream handshake
//   pix_x,pix_y,pix_addr     : pixel coordinate and framebuffer address
//   pix_last                 : final pixel of the line
//   line_done                : one-cycle pulse after the final pixel
//   busy                     : not idle
// ---------------------------------------------------------------------------
module bresen_line_gen
   import gpu_pkg::*;
#(
   parameter int X_W       = 10,
   parameter int Y_W       = 9,
   parameter int ADDR_MODE = ADDR_CONCAT,
   parameter int FB_WIDTH  = 640,
   parameter int ADDR_W    = 19
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [X_W-1:0]    cmd_x0,
   input  logic [X_W-1:0]    cmd_x1,
   input  logic [Y_W-1:0]    cmd_y0,
   input  logic [Y_W-1:0]    cmd_y1,
   input  logic              cmd_skip_last,
   input  logic              abort,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic [X_W-1:0]    pix_x,
   output logic [Y_W-1:0]    pix_y,
   output logic [ADDR_W-1:0] pix_addr,
   output logic              pix_last,
   output logic              line_done,
   output logic              busy
);

   localparam int D_W = ((X_W > Y_W) ? X_W : Y_W) + 2;
   localparam logic [ADDR_W-1:0] PITCH = ADDR_W'(FB_WIDTH);

   line_state_t             state_reg, state_next;
   logic [X_W-1:0]          x0_reg, x0_next, x1_reg, x1_next;
   logic [Y_W-1:0]          y0_reg, y0_next, y1_reg, y1_next;
   logic                    skip_reg, skip_next;
   logic [X_W-1:0]          x_reg, x_next;
   logic [Y_W-1:0]          y_reg, y_next;
   logic [ADDR_W-1:0]       addr_reg, addr_next;
   logic signed [D_W-1:0]   err_reg, err_next;
   logic signed [D_W-1:0]   dx_reg, dx_next;
   logic signed [D_W-1:0]   dy_reg, dy_next;
   logic                    sx_neg_reg, sx_neg_next;
   logic                    sy_neg_reg, sy_neg_next;
   logic                    line_done_reg, line_done_next;

   // Setup arithmetic on the latched end points
   logic signed [D_W-1:0]   diff_x, diff_y;
   logic signed [D_W-1:0]   setup_dx, setup_dy;
   logic [ADDR_W-1:0]       setup_addr;

   // Stepper outputs
   logic [X_W-1:0]          step_x;
   logic [Y_W-1:0]          step_y;
   logic [ADDR_W-1:0]       step_addr;
   logic signed [D_W-1:0]   step_err;
   logic                    step_is_end;
   logic                    cur_is_end;
   logic                    pix_hs;

   // The same stepper serves both the real step and the skip_last look-ahead:
   // with skip set, the current pixel is last when its successor is the end.
   bresen_step #(
      .X_W       (X_W),
      .Y_W       (Y_W),
      .D_W       (D_W),
      .ADDR_W    (ADDR_W),
      .ADDR_MODE (ADDR_MODE),
      .FB_WIDTH  (FB_WIDTH)
   ) u_step (
      .x           (x_reg),
      .y           (y_reg),
      .addr        (addr_reg),
      .err         (err_reg),
      .dx          (dx_reg),
      .dy          (dy_reg),
      .sx_neg      (sx_neg_reg),
      .sy_neg      (sy_neg_reg),
      .x_end       (x1_reg),
      .y_end       (y1_reg),
      .x_n         (step_x),
      .y_n         (step_y),
      .addr_n      (step_addr),
      .err_n       (step_err),
      .next_is_end (step_is_end)
   );

   assign cur_is_end = (x_reg == x1_reg) && (y_reg == y1_reg);

   assign cmd_ready = (state_reg == IDLE) && !rst && !abort;
   assign pix_valid = (state_reg == DRAW);
   assign pix_last  = (state_reg == DRAW) && (skip_reg ? step_is_end : cur_is_end);
   assign pix_hs    = pix_valid && pix_ready;
   assign pix_x     = x_reg;
   assign pix_y     = y_reg;
   assign pix_addr  = addr_reg;
   assign line_done = line_done_reg;
   assign busy      = (state_reg != IDLE);

   always_comb begin
      diff_x   = $signed(D_W'(x1_reg)) - $signed(D_W'(x0_reg));
      diff_y   = $signed(D_W'(y1_reg)) - $signed(D_W'(y0_reg));
      setup_dx = diff_x[D_W-1] ? -diff_x : diff_x;
      setup_dy = diff_y[D_W-1] ? diff_y : -diff_y;
      // The only multiply in the design; later steps add/subtract the pitch.
      if (ADDR_MODE == ADDR_LINEAR) begin
         setup_addr = ADDR_W'(y0_reg) * PITCH + ADDR_W'(x0_reg);
      end else begin
         setup_addr = ADDR_W'({x0_reg, y0_reg});
      end
   end

   always_comb begin
      state_next     = state_reg;
      x0_next        = x0_reg;
      y0_next        = y0_reg;
      x1_next        = x1_reg;
      y1_next        = y1_reg;
      skip_next      = skip_reg;
      x_next         = x_reg;
      y_next         = y_reg;
      addr_next      = addr_reg;
      err_next       = err_reg;
      dx_next        = dx_reg;
      dy_next        = dy_reg;
      sx_neg_next    = sx_neg_reg;
      sy_neg_next    = sy_neg_reg;
      line_done_next = 1'b0;

      case (state_reg)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               x0_next    = cmd_x0;
               y0_next    = cmd_y0;
               x1_next    = cmd_x1;
               y1_next    = cmd_y1;
               skip_next  = cmd_skip_last;
               state_next = SETUP;
            end
         end
         SETUP: begin
            dx_next     = setup_dx;
            dy_next     = setup_dy;
            err_next    = setup_dx + setup_dy;
            sx_neg_next = (x1_reg < x0_reg);
            sy_neg_next = (y1_reg < y0_reg);
            x_next      = x0_reg;
            y_next      = y0_reg;
            addr_next   = setup_addr;
            // A zero-length line with its only pixel skipped draws nothing.
            if (skip_reg && (x0_reg == x1_reg) && (y0_reg == y1_reg)) begin
               state_next     = IDLE;
               line_done_next = 1'b1;
            end else begin
               state_next = DRAW;
            end
         end
         DRAW: begin
            if (pix_hs) begin
               if (pix_last) begin
                  state_next     = IDLE;
                  line_done_next = 1'b1;
               end else begin
                  x_next    = step_x;
                  y_next    = step_y;
                  addr_next = step_addr;
                  err_next  = step_err;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // Abort wins over any handshake or accept in the same cycle.
      if (abort) begin
         state_next     = IDLE;
         line_done_next = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         x0_reg        <= '0;
         y0_reg        <= '0;
         x1_reg        <= '0;
         y1_reg        <= '0;
         skip_reg      <= 1'b0;
         x_reg         <= '0;
         y_reg         <= '0;
         addr_reg      <= '0;
         err_reg       <= '0;
         dx_reg        <= '0;
         dy_reg        <= '0;
         sx_neg_reg    <= 1'b0;
         sy_neg_reg    <= 1'b0;
         line_done_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         x0_reg        <= x0_next;
         y0_reg        <= y0_next;
         x1_reg        <= x1_next;
         y1_reg        <= y1_next;
         skip_reg      <= skip_next;
         x_reg         <= x_next;
         y_reg         <= y_next;
         addr_reg      <= addr_next;
         err_reg       <= err_next;
         dx_reg        <= dx_next;
         dy_reg        <= dy_next;
         sx_neg_reg    <= sx_neg_next;
         sy_neg_reg    <= sy_neg_next;
         line_done_reg <= line_done_next;
      end
   end

endmodule

// File: tb/tb_bresen_line_gen.sv
// ---------------------------------------------------------------------------
// tb_bresen_line_gen
// Two rasterisers (concatenated and linear addressing) share one command bus
// and one pixel-ready line. Expected pixels come from an integer Bresenham
// walk and are queued per instance; monitors pop and compare on handshakes.
// ---------------------------------------------------------------------------
module tb_bresen_line_gen;

   localparam int X_W    = 10;
   localparam int Y_W    = 9;
   localparam int ADDR_W = 19;
   localparam int FBW    = 640;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic              cmd_valid;
   logic [X_W-1:0]    cmd_x0, cmd_x1;
   logic [Y_W-1:0]    cmd_y0, cmd_y1;
   logic              cmd_skip_last;
   logic              abort;
   logic              pix_ready;

   logic              c_cmd_ready, c_pix_valid, c_pix_last, c_line_done, c_busy;
   logic [X_W-1:0]    c_pix_x;
   logic [Y_W-1:0]    c_pix_y;
   logic [ADDR_W-1:0] c_pix_addr;
   logic              l_cmd_ready, l_pix_valid, l_pix_last, l_line_done, l_busy;
   logic [X_W-1:0]    l_pix_x;
   logic [Y_W-1:0]    l_pix_y;
   logic [ADDR_W-1:0] l_pix_addr;

   bresen_line_gen #(.X_W(X_W), .Y_W(Y_W), .ADDR_MODE(0), .FB_WIDTH(FBW), .ADDR_W(ADDR_W)) dut_c (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(c_cmd_ready),
      .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0), .cmd_y1(cmd_y1),
      .cmd_skip_last(cmd_skip_last), .abort(abort),
      .pix_valid(c_pix_valid), .pix_ready(pix_ready), .pix_x(c_pix_x), .pix_y(c_pix_y),
      .pix_addr(c_pix_addr), .pix_last(c_pix_last), .line_done(c_line_done), .busy(c_busy)
   );

   bresen_line_gen #(.X_W(X_W), .Y_W(Y_W), .ADDR_MODE(1), .FB_WIDTH(FBW), .ADDR_W(ADDR_W)) dut_l (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(l_cmd_ready),
      .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0), .cmd_y1(cmd_y1),
      .cmd_skip_last(cmd_skip_last), .abort(abort),
      .pix_valid(l_pix_valid), .pix_ready(pix_ready), .pix_x(l_pix_x), .pix_y(l_pix_y),
      .pix_addr(l_pix_addr), .pix_last(l_pix_last), .line_done(l_line_done), .busy(l_busy)
   );

   typedef struct {
      int x;
      int y;
      bit last;
   } pix_t;

   pix_t q0[$];
   pix_t q1[$];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int hs0 = 0;
   int hs1 = 0;
   int last_hs_edge = 0;
   bit rdy_rand = 1'b0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (rdy_rand) pix_ready = ($urandom_range(0, 3) != 0);
   end

   function automatic void check_pix(int id, int ax, int ay, int aaddr, bit alast);
      pix_t e;
      int   eaddr;
      checks++;
      if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
         failures++;
         $display("FAIL unexpected_pixel dut%0d got x=%0d y=%0d required no pixel", id, ax, ay);
         return;
      end
      if (id == 0) e = q0.pop_front();
      else         e = q1.pop_front();
      if (id == 0) eaddr = e.x * (1 << Y_W) + e.y;
      else         eaddr = (e.y * FBW + e.x) % (1 << ADDR_W);
      if (ax != e.x || ay != e.y || aaddr != eaddr || alast != e.last) begin
         failures++;
         $display("FAIL pixel dut%0d got x=%0d y=%0d addr=%0d last=%0d required x=%0d y=%0d addr=%0d last=%0d",
                  id, ax, ay, aaddr, alast, e.x, e.y, eaddr, e.last);
      end
   endfunction

   // Monitor for the concatenated instance, including stall stability.
   initial begin : mon_c
      bit hold;
      logic [X_W+Y_W+ADDR_W:0] held;
      hold = 1'b0;
      held = '0;
      forever begin
         @(negedge clk);
         if (hold && c_pix_valid) begin
            checks++;
            if ({c_pix_x, c_pix_y, c_pix_addr, c_pix_last} != held) begin
               failures++;
               $display("FAIL stall_hold got x=%0d y=%0d addr=%0d required x=%0d y=%0d addr=%0d",
                        c_pix_x, c_pix_y, c_pix_addr,
                        held[X_W+Y_W+ADDR_W:Y_W+ADDR_W+1], held[Y_W+ADDR_W:ADDR_W+1], held[ADDR_W:1]);
            end
         end
         if (c_pix_valid && pix_ready) begin
            check_pix(0, int'(c_pix_x), int'(c_pix_y), int'(c_pix_addr), c_pix_last);
            hs0++;
            last_hs_edge = cyc + 1;
         end
         hold = c_pix_valid && !pix_ready;
         held = {c_pix_x, c_pix_y, c_pix_addr, c_pix_last};
      end
   end

   initial begin : mon_l
      forever begin
         @(negedge clk);
         if (l_pix_valid && pix_ready) begin
            check_pix(1, int'(l_pix_x), int'(l_pix_y), int'(l_pix_addr), l_pix_last);
            hs1++;
         end
      end
   end

   task automatic chk(input string name, input int got, input int req);
      checks++;
      if (got != req) begin
         failures++;
         $display("FAIL %s got=%0d required=%0d", name, got, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: integer Bresenham walk from the end-point rules.
   task automatic expect_line(input int x0, input int y0, input int x1, input int y1,
                              input bit skip, output int n);
      int   dx, dy, sx, sy, err, e2, x, y;
      pix_t lst[$];
      pix_t p;
      dx  = (x1 > x0) ? x1 - x0 : x0 - x1;
      dy  = -((y1 > y0) ? y1 - y0 : y0 - y1);
      sx  = (x1 >= x0) ? 1 : -1;
      sy  = (y1 >= y0) ? 1 : -1;
      err = dx + dy;
      x   = x0;
      y   = y0;
      while (lst.size() < 4096) begin
         p.x = x; p.y = y; p.last = 1'b0;
         lst.push_back(p);
         if (x == x1 && y == y1) break;
         e2 = 2 * err;
         if (e2 >= dy) begin err += dy; x += sx; end
         if (e2 <= dx) begin err += dx; y += sy; end
      end
      if (skip) void'(lst.pop_back());
      if (lst.size() > 0) begin
         p = lst.pop_back();
         p.last = 1'b1;
         lst.push_back(p);
      end
      foreach (lst[i]) begin
         q0.push_back(lst[i]);
         q1.push_back(lst[i]);
      end
      n = lst.size();
   endtask

   // Presents a command; called and returns just after a rising edge.
   task automatic send_cmd(input int x0, input int y0, input int x1, input int y1,
                           input bit skip, output int acc);
      cmd_x0        = X_W'(x0);
      cmd_y0        = Y_W'(y0);
      cmd_x1        = X_W'(x1);
      cmd_y1        = Y_W'(y1);
      cmd_skip_last = skip;
      cmd_valid     = 1'b1;
      acc = -1;
      for (int k = 0; k < 20 && acc < 0; k++) begin
         @(negedge clk);
         if (c_cmd_ready) acc = cyc + 1;
         tick();
      end
      cmd_valid = 1'b0;
      if (acc < 0) chk("cmd_accept_timeout", 0, 1);
   endtask

   task automatic run_line(input int x0, input int y0, input int x1, input int y1,
                           input bit skip, input bit rnd, input string tag);
      int n, acc, hs_start, exp_cnt, adx, ady, budget, done_cyc;
      bit seen, done;
      expect_line(x0, y0, x1, y1, skip, n);
      adx = (x1 > x0) ? x1 - x0 : x0 - x1;
      ady = (y1 > y0) ? y1 - y0 : y0 - y1;
      exp_cnt = ((adx > ady) ? adx : ady) + 1 - int'(skip);
      rdy_rand = rnd;
      if (!rnd) pix_ready = 1'b1;
      hs_start = hs0;
      send_cmd(x0, y0, x1, y1, skip, acc);
      seen = 1'b0;
      done = 1'b0;
      done_cyc = 0;
      budget = 4 * n + 50;
      if (acc >= 0) begin
         for (int k = 0; k < budget && !done; k++) begin
            @(negedge clk);
            if (!seen && c_pix_valid) begin
               seen = 1'b1;
               chk({tag, "_first_valid_latency"}, cyc - acc, 1);
               if (n == 0) chk({tag, "_valid_on_empty_line"}, 1, 0);
            end
            if (c_line_done) begin
               done = 1'b1;
               done_cyc = cyc;
            end
         end
      end
      if (!done) begin
         chk({tag, "_line_done_timeout"}, 0, 1);
         abort = 1'b1;
         tick();
         abort = 1'b0;
      end else begin
         chk({tag, "_line_done_cycle"}, done_cyc, (n > 0) ? last_hs_edge : acc + 1);
         chk({tag, "_cmd_ready_with_done"}, int'(c_cmd_ready), 1);
         chk({tag, "_linear_done"}, int'(l_line_done), 1);
         chk({tag, "_pixel_count"}, hs0 - hs_start, exp_cnt);
         chk({tag, "_queue_c_left"}, q0.size(), 0);
         chk({tag, "_queue_l_left"}, q1.size(), 0);
         @(negedge clk);
         chk({tag, "_done_one_cycle"}, int'(c_line_done), 0);
         tick();
      end
      q0.delete();
      q1.delete();
      rdy_rand = 1'b0;
   endtask

   initial begin : watchdog
      #4ms;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int acc, hs_start, mx, my, x0, y0, x1, y1;
      bit sk, rn;
      rst = 1'b1; cmd_valid = 1'b0; abort = 1'b0; pix_ready = 1'b0;
      cmd_x0 = '0; cmd_x1 = '0; cmd_y0 = '0; cmd_y1 = '0; cmd_skip_last = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cmd_ready", int'(c_cmd_ready), 0);
      chk("rst_pix_valid", int'(c_pix_valid), 0);
      chk("rst_busy", int'(c_busy | l_busy), 0);
      chk("rst_line_done", int'(c_line_done), 0);
      chk("rst_pix_xy", int'(c_pix_x) + int'(c_pix_y) + int'(c_pix_addr), 0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_cmd_ready", int'(c_cmd_ready & l_cmd_ready), 1);
      tick();

      run_line(0, 0, 3, 1, 1'b0, 1'b0, "short");
      run_line(5, 5, 2, 9, 1'b0, 1'b0, "steep_back");
      run_line(7, 3, 7, 3, 1'b0, 1'b0, "point");
      run_line(7, 3, 7, 3, 1'b1, 1'b0, "point_skip");
      run_line(0, 0, 4, 4, 1'b1, 1'b1, "diag_skip_stall");

      // Abort after ten pixels of a long horizontal line.
      begin
         int n;
         expect_line(0, 0, 100, 0, 1'b0, n);
         pix_ready = 1'b1;
         hs_start = hs0;
         send_cmd(0, 0, 100, 0, 1'b0, acc);
         for (int k = 0; k < 200 && hs0 - hs_start < 10; k++) tick();
         abort = 1'b1;
         pix_ready = 1'b0;
         tick();
         abort = 1'b0;
         @(negedge clk);
         chk("abort_pix_valid", int'(c_pix_valid), 0);
         chk("abort_busy", int'(c_busy | l_busy), 0);
         chk("abort_cmd_ready", int'(c_cmd_ready), 1);
         chk("abort_handshakes", hs0 - hs_start, 10);
         for (int k = 0; k < 3; k++) begin
            chk("abort_no_done", int'(c_line_done | l_line_done), 0);
            @(negedge clk);
         end
         tick();
         q0.delete();
         q1.delete();
      end
      run_line(0, 0, 5, 2, 1'b0, 1'b0, "after_abort");

      // Reset in the middle of a full-screen diagonal.
      begin
         int n;
         expect_line(639, 479, 0, 0, 1'b0, n);
         rdy_rand = 1'b1;
         hs_start = hs0;
         send_cmd(639, 479, 0, 0, 1'b0, acc);
         for (int k = 0; k < 1000 && hs0 - hs_start < 50; k++) tick();
         rdy_rand = 1'b0;
         pix_ready = 1'b0;
         rst = 1'b1;
         tick();
         @(negedge clk);
         chk("midrst_pix_valid", int'(c_pix_valid | l_pix_valid), 0);
         chk("midrst_busy", int'(c_busy), 0);
         chk("midrst_cmd_ready", int'(c_cmd_ready), 0);
         chk("midrst_line_done", int'(c_line_done), 0);
         chk("midrst_pix_last", int'(c_pix_last), 0);
         chk("midrst_pix_x", int'(c_pix_x), 0);
         chk("midrst_pix_y", int'(c_pix_y), 0);
         chk("midrst_pix_addr", int'(c_pix_addr) + int'(l_pix_addr), 0);
         tick();
         rst = 1'b0;
         q0.delete();
         q1.delete();
         @(negedge clk);
         chk("midrst_release_ready", int'(c_cmd_ready), 1);
         tick();
      end
      run_line(639, 479, 0, 0, 1'b0, 1'b1, "full_diag");

      for (int i = 0; i < 24; i++) begin
         mx = ($urandom_range(0, 3) == 0) ? 1023 : 31;
         my = ($urandom_range(0, 3) == 0) ? 511 : 31;
         x0 = int'($urandom_range(0, mx));
         y0 = int'($urandom_range(0, my));
         x1 = int'($urandom_range(0, mx));
         y1 = int'($urandom_range(0, my));
         sk = ($urandom_range(0, 1) == 1);
         rn = ($urandom_range(0, 1) == 1);
         run_line(x0, y0, x1, y1, sk, rn, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
